ft64_gpu_bus_responder: RTL and testbench
=========================================

Name: ft64_gpu_bus_responder

Overview:
- Target-side end of the GPU tagged bus. Sits behind the GPU bus mux's single master port.
- Accepts one tagged request at a time (15-bit requester tag, classic cyc/stb/we/sel/adr/dat) and performs the access on a downstream single-port memory/slave bus.
- Returns a one-cycle ack carrying the request's tag on rsp_o, plus read data.
- Provides a timeout/error path so a dead downstream slave cannot hang a GPU requester.

Parameters:
- TAG_W, 15, width of request/response tag.
- TIMEOUT, 64, downstream cycles without mem_ack_i before an error response is issued (min 2).
- IDLE_TAG, 15'h7FFE, value of rsp_o out of reset.
- ERR_DATA, 32'hDEADBEEF, dat_o value returned on a timed-out read.

Ports:
- clk_i  in  1  clock; everything is on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_i  in  TAG_W  requester tag of the current request.
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  request strobe; held by the requester until acked.
- we_i  in  1  write enable.
- sel_i  in  4  byte selects.
- adr_i  in  32  byte address.
- dat_i  in  32  write data.
- ack_o  out  1  response valid, one-cycle pulse.
- err_o  out  1  response is a timeout error; qualified by ack_o.
- rsp_o  out  TAG_W  tag of the response being acked.
- dat_o  out  32  read data.
- mem_cyc_o  out  1  downstream cycle.
- mem_stb_o  out  1  downstream strobe.
- mem_ack_i  in  1  downstream acknowledge.
- mem_we_o  out  1  downstream write enable.
- mem_sel_o  out  4  downstream byte selects.
- mem_adr_o  out  32  downstream address.
- mem_dat_o  out  32  downstream write data.
- mem_dat_i  in  32  downstream read data.

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE.
  - ack_o=0, err_o=0, rsp_o=IDLE_TAG, dat_o=0.
  - All mem_* outputs 0; mem_cyc_o and mem_stb_o drop immediately, even mid-transaction.
  - last_vld=0, timeout counter=0.
- All outputs are registered.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Accept when cyc_i & stb_i and NOT (last_vld & req_i==last_tag).
  - On accept, capture tag/we/sel/adr/dat, drive mem_cyc_o=mem_stb_o=1 with the captured fields, clear the counter, go to ISSUE.
- ISSUE:
  - If mem_ack_i:
    - drop mem_cyc_o/mem_stb_o;
    - load dat_o<=mem_dat_i for reads only (writes leave dat_o unchanged);
    - ack_o<=1, err_o<=0, rsp_o<=captured tag;
    - go to RESP.
  - Else if counter==TIMEOUT-1:
    - drop mem_cyc_o/mem_stb_o;
    - ack_o<=1, err_o<=1, rsp_o<=tag;
    - reads load dat_o<=ERR_DATA;
    - go to RESP.
  - Else counter increments.
  - mem_ack_i and timeout on the same cycle: ack wins, err_o=0.
- RESP:
  - ack_o and err_o clear next cycle (exactly one-cycle pulse); rsp_o holds its value.
  - Set last_vld=1, last_tag=tag; go to IDLE.
- last_vld clears on any cycle where !(cyc_i & stb_i). This prevents re-accepting a still-asserted strobe for an already-answered tag.
- A new tag with the strobe held high is accepted back-to-back.
- cyc_i dropping during ISSUE does not abort: the downstream access completes and the response is still pulsed (the requester's tag compare discards it).
- Latency:
  - Request sampled at edge E0 → mem_stb_o high after E0.
  - mem_ack_i sampled at edge E1 → ack_o high for E1..E2.
  - Minimum request-to-ack is 2 cycles.
- Counter width is clog2(TIMEOUT); no wrap is possible because the counter exits at TIMEOUT-1.

Decomposition:
- Shared package ft64_gpu_bus_pkg holds TAG_W, IDLE_TAG, ERR_DATA and the state enum (IDLE/ISSUE/RESP). The same constants are used by the GPU bus mux.
- No sub-module is needed. The timeout counter is inline.

Test Plan:
- Read, tag 15'h0003, adr 32'h100, mem acks 1 cycle after strobe with 32'h12345678 → ack_o pulse 1 cycle, rsp_o=15'h0003, dat_o=32'h12345678, err_o=0; mem_stb_o seen exactly once.
- Write, tag 15'h0005, sel 4'hC, dat 32'hA5A5A5A5, mem ack after 3 waits → mem_we_o=1, mem_sel_o=4'hC, mem_dat_o=A5A5A5A5; ack_o on the cycle after mem_ack_i; dat_o unchanged.
- Requester holds stb_i high with tag 15'h0003 for 10 cycles after ack → no second downstream access. Tag then changes to 15'h0004 with the strobe still high → second access accepted.
- Read, mem never acks, TIMEOUT=64 → ack_o and err_o at 64 cycles after the strobe, dat_o=32'hDEADBEEF, mem_cyc_o dropped.
- mem_ack_i arrives exactly on cycle TIMEOUT-1 → normal ack with err_o=0 and memory data.
- rst_ni asserted mid-ISSUE → mem_cyc_o/mem_stb_o low without waiting for a clock edge, rsp_o=15'h7FFE. After release, a fresh request completes normally.

Source files
------------

// File: rtl/ft64_gpu_bus_pkg.sv
// Purpose: constants and types shared by the GPU tagged-bus blocks (mux and responder).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ft64_gpu_bus_pkg;

   localparam int                TAG_W    = 15;
   localparam logic [TAG_W-1:0]  IDLE_TAG = 15'h7FFE;
   localparam logic [31:0]       ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // One captured request, held stable while the downstream access runs.
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             we;
      logic [3:0]       sel;
      logic [31:0]      adr;
      logic [31:0]      dat;
   } req_t;

endpackage

// File: rtl/ft64_gpu_bus_responder_if.sv
// Purpose: GPU tagged-bus target port plus the downstream memory/slave bus, as one bundle.
// Latency: n/a (wiring only).
// Backpressure: requester holds stb_i until ack_o; downstream holds ack until mem_ack_i.
// Ports (slave view): req_i/cyc_i/stb_i/we_i/sel_i/adr_i/dat_i in, ack_o/err_o/rsp_o/dat_o out,
//   mem_cyc_o/mem_stb_o/mem_we_o/mem_sel_o/mem_adr_o/mem_dat_o out, mem_ack_i/mem_dat_i in.
interface ft64_gpu_bus_responder_if;
   import ft64_gpu_bus_pkg::*;

   logic [TAG_W-1:0] req_i;
   logic             cyc_i;
   logic             stb_i;
   logic             we_i;
   logic [3:0]       sel_i;
   logic [31:0]      adr_i;
   logic [31:0]      dat_i;
   logic             ack_o;
   logic             err_o;
   logic [TAG_W-1:0] rsp_o;
   logic [31:0]      dat_o;

   logic             mem_cyc_o;
   logic             mem_stb_o;
   logic             mem_ack_i;
   logic             mem_we_o;
   logic [3:0]       mem_sel_o;
   logic [31:0]      mem_adr_o;
   logic [31:0]      mem_dat_o;
   logic [31:0]      mem_dat_i;

   // The responder side.
   modport slave (
      input  req_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
      output ack_o, err_o, rsp_o, dat_o,
      output mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_adr_o, mem_dat_o,
      input  mem_ack_i, mem_dat_i
   );

   // The requester plus downstream memory side.
   modport master (
      output req_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
      input  ack_o, err_o, rsp_o, dat_o,
      input  mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o, mem_adr_o, mem_dat_o,
      output mem_ack_i, mem_dat_i
   );

endinterface

// File: rtl/ft64_gpu_bus_responder.sv
// Purpose: target end of the GPU tagged bus; runs one request at a time on a downstream bus.
// Latency: request edge -> mem_stb_o next cycle; mem_ack_i edge -> one-cycle ack_o; min 2 cycles.
// Backpressure: one request in flight; requester strobe is held until ack; timeout after TIMEOUT cycles.
// Ports: clk_i, rst_ni (async, active low), bus (slave modport: tagged request/response
//   and downstream memory bus). All bus outputs are registered.
module ft64_gpu_bus_responder
   import ft64_gpu_bus_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   ft64_gpu_bus_responder_if.slave   bus
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   req_t             cap_q, cap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_vld_q, last_vld_d;
   logic [TAG_W-1:0] last_tag_q, last_tag_d;
   logic             stb_q, stb_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic [TAG_W-1:0] rsp_q, rsp_d;
   logic [31:0]      dat_q, dat_d;

   logic req_act;
   logic accept;
   logic timeout;

   assign req_act = bus.cyc_i & bus.stb_i;
   // A strobe that is still up for the tag just answered must not start a second access.
   assign accept  = (state_q == IDLE) & req_act &
                    !(last_vld_q & (bus.req_i == last_tag_q));
   assign timeout = (cnt_q == CNT_LAST);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   if (bus.mem_ack_i || timeout) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values; all of them are registered below.
   always_comb begin
      cap_d      = cap_q;
      cnt_d      = cnt_q;
      last_vld_d = last_vld_q;
      last_tag_d = last_tag_q;
      stb_d      = stb_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      rsp_d      = rsp_q;
      dat_d      = dat_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cap_d = '{tag: bus.req_i, we: bus.we_i, sel: bus.sel_i,
                         adr: bus.adr_i, dat: bus.dat_i};
               stb_d = 1'b1;
               cnt_d = '0;
            end
         end
         ISSUE: begin
            // A real ack takes priority over a timeout landing on the same edge.
            if (bus.mem_ack_i) begin
               stb_d = 1'b0;
               ack_d = 1'b1;
               rsp_d = cap_q.tag;
               if (!cap_q.we) dat_d = bus.mem_dat_i;
            end else if (timeout) begin
               stb_d = 1'b0;
               ack_d = 1'b1;
               err_d = 1'b1;
               rsp_d = cap_q.tag;
               if (!cap_q.we) dat_d = ERR_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            last_vld_d = 1'b1;
            last_tag_d = cap_q.tag;
         end
         default: ;
      endcase
      // Once the requester lets go of the strobe, the same tag may be issued again.
      if (!req_act) last_vld_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cap_q      <= '0;
         cnt_q      <= '0;
         last_vld_q <= 1'b0;
         last_tag_q <= '0;
         stb_q      <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rsp_q      <= IDLE_TAG;
         dat_q      <= '0;
      end else begin
         cap_q      <= cap_d;
         cnt_q      <= cnt_d;
         last_vld_q <= last_vld_d;
         last_tag_q <= last_tag_d;
         stb_q      <= stb_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rsp_q      <= rsp_d;
         dat_q      <= dat_d;
      end
   end

   assign bus.ack_o     = ack_q;
   assign bus.err_o     = err_q;
   assign bus.rsp_o     = rsp_q;
   assign bus.dat_o     = dat_q;
   assign bus.mem_cyc_o = stb_q;
   assign bus.mem_stb_o = stb_q;
   assign bus.mem_we_o  = cap_q.we;
   assign bus.mem_sel_o = cap_q.sel;
   assign bus.mem_adr_o = cap_q.adr;
   assign bus.mem_dat_o = cap_q.dat;

endmodule

// File: tb/tb_ft64_gpu_bus_responder.sv
// Purpose: self-checking bench for ft64_gpu_bus_responder with directed and random requests.
// Latency: n/a.
// Backpressure: bench plays requester and downstream memory with programmable wait states.
module tb_ft64_gpu_bus_responder;
   import ft64_gpu_bus_pkg::*;

   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [31:0] exp_dat = 32'h0;   // model of dat_o: last read result

   ft64_gpu_bus_responder_if bus();

   ft64_gpu_bus_responder #(.TIMEOUT(TIMEOUT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req_i     = '0;
      bus.cyc_i     = 1'b0;
      bus.stb_i     = 1'b0;
      bus.we_i      = 1'b0;
      bus.sel_i     = 4'h0;
      bus.adr_i     = 32'h0;
      bus.dat_i     = 32'h0;
      bus.mem_ack_i = 1'b0;
      bus.mem_dat_i = 32'h0;
   endtask

   // Issue one request from a negedge. The memory acks after 'waits' cycles of strobe.
   // Expected: ack on edge min(waits+1, TIMEOUT) after acceptance, error when waits+1 > TIMEOUT.
   task automatic do_req(input logic [TAG_W-1:0] tag, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] wdat, input int waits,
                         input logic [31:0] rdata, input logic hold);
      int   k;
      int   ack_k;
      int   stb_cnt;
      int   exp_k;
      logic exp_err;
      exp_k   = (waits + 1 < TIMEOUT) ? waits + 1 : TIMEOUT;
      exp_err = (waits + 1 > TIMEOUT);
      bus.req_i = tag;
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = we;
      bus.sel_i = sel;
      bus.adr_i = adr;
      bus.dat_i = wdat;
      k = 0;
      ack_k = -1;
      stb_cnt = 0;
      @(posedge clk);
      while (ack_k < 0 && k < 200) begin
         @(negedge clk);
         if (bus.ack_o) begin
            ack_k = k;
         end else begin
            if (bus.mem_stb_o) begin
               stb_cnt++;
               if (stb_cnt == 1) begin
                  chk("mem_cyc", bus.mem_cyc_o, 1);
                  chk("mem_we", bus.mem_we_o, we);
                  chk("mem_sel", bus.mem_sel_o, sel);
                  chk("mem_adr", bus.mem_adr_o, adr);
                  chk("mem_dat", bus.mem_dat_o, wdat);
               end
            end
            bus.mem_ack_i = (k == waits);
            bus.mem_dat_i = (k == waits) ? rdata : $urandom();
            @(posedge clk);
            k++;
         end
      end
      chk("ack_latency", ack_k, exp_k);
      chk("stb_cycles", stb_cnt, exp_k);
      if (!we) exp_dat = exp_err ? ERR_DATA : rdata;
      chk("err", bus.err_o, exp_err);
      chk("rsp", bus.rsp_o, tag);
      chk("dat", bus.dat_o, exp_dat);
      chk("mem_cyc_dropped", bus.mem_cyc_o, 0);
      bus.mem_ack_i = 1'b0;
      if (!hold) begin
         bus.cyc_i = 1'b0;
         bus.stb_i = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("ack_pulse", bus.ack_o, 0);
      chk("err_clear", bus.err_o, 0);
      chk("rsp_hold", bus.rsp_o, tag);
   endtask

   initial begin
      int stb_seen;
      int waits;
      logic we;
      logic [31:0] rd;
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state.
      chk("rst_ack", bus.ack_o, 0);
      chk("rst_err", bus.err_o, 0);
      chk("rst_rsp", bus.rsp_o, IDLE_TAG);
      chk("rst_dat", bus.dat_o, 0);
      chk("rst_mem_cyc", bus.mem_cyc_o, 0);
      chk("rst_mem_stb", bus.mem_stb_o, 0);
      chk("rst_mem_we", bus.mem_we_o, 0);
      chk("rst_mem_sel", bus.mem_sel_o, 0);
      chk("rst_mem_adr", bus.mem_adr_o, 0);
      chk("rst_mem_dat", bus.mem_dat_o, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic read, memory acks right away.
      do_req(15'h0003, 1'b0, 4'hF, 32'h100, 32'h0, 0, 32'h12345678, 1'b0);
      // Write with three wait states; dat_o keeps the previous read.
      do_req(15'h0005, 1'b1, 4'hC, 32'h200, 32'hA5A5A5A5, 3, 32'h0BAD0BAD, 1'b0);

      // Strobe held after the ack with the same tag: no second access.
      do_req(15'h0003, 1'b0, 4'hF, 32'h104, 32'h0, 1, 32'h11112222, 1'b1);
      stb_seen = 0;
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.mem_stb_o) stb_seen++;
      end
      chk("held_tag_no_reaccess", stb_seen, 0);
      // New tag with the strobe still high is taken back-to-back.
      do_req(15'h0004, 1'b0, 4'hF, 32'h108, 32'h0, 0, 32'h33334444, 1'b0);

      // Dead slave: error response with ERR_DATA.
      do_req(15'h0009, 1'b0, 4'hF, 32'h300, 32'h0, 1000, 32'h0, 1'b0);
      // Dead slave on a write: error, dat_o unchanged.
      do_req(15'h000B, 1'b1, 4'h3, 32'h304, 32'hCAFEF00D, 1000, 32'h0, 1'b0);
      // Ack on the last possible cycle beats the timeout.
      do_req(15'h000A, 1'b0, 4'hF, 32'h400, 32'h0, TIMEOUT - 1, 32'h600DCAFE, 1'b0);

      // Random traffic, including occasional runs near/over the timeout.
      for (int i = 0; i < 16; i++) begin
         we    = 1'($urandom_range(0, 1));
         waits = ($urandom_range(0, 5) == 0) ? TIMEOUT - 2 + int'($urandom_range(0, 3))
                                             : int'($urandom_range(0, 6));
         rd    = $urandom();
         do_req(TAG_W'($urandom()), we, 4'($urandom()), $urandom(), $urandom(),
                waits, rd, 1'b0);
      end

      // Reset in the middle of a downstream access.
      bus.req_i = 15'h0011;
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.we_i  = 1'b0;
      bus.sel_i = 4'hF;
      bus.adr_i = 32'h500;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_mem_stb", bus.mem_stb_o, 1);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_mem_cyc", bus.mem_cyc_o, 0);
      chk("mid_rst_mem_stb", bus.mem_stb_o, 0);
      chk("mid_rst_rsp", bus.rsp_o, IDLE_TAG);
      chk("mid_rst_ack", bus.ack_o, 0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      exp_dat = 32'h0;
      chk("post_rst_dat", bus.dat_o, exp_dat);
      @(negedge clk);
      do_req(15'h0012, 1'b0, 4'hF, 32'h600, 32'h0, 2, 32'h89ABCDEF, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
